// File: rtl/ro_meter_pkg.sv
// Shared types and defaults for the ring-oscillator frequency meter.
// The state encoding and the timer-width rule live here.
package ro_meter_pkg;

  localparam int DEF_COUNT_W    = 16;
  localparam int DEF_GATE_CYC   = 1024;
  localparam int DEF_SETTLE_CYC = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } meter_state_e;

  // Bits needed to hold max(gate_cyc, settle_cyc) - 1.
  function automatic int timer_width(input int gate_cyc, input int settle_cyc);
    int longest;
    longest = (gate_cyc > settle_cyc) ? gate_cyc : settle_cyc;
    return (longest < 2) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/ro_freq_meter_if.sv
// Control, oscillator and result signals of the frequency meter.
// The meter side uses the slave modport; the tile control side uses master.
interface ro_freq_meter_if #(
  parameter int COUNT_W = ro_meter_pkg::DEF_COUNT_W
);
  logic               start;
  logic               abort;
  logic               ro_in;
  logic               ro_activate;
  logic               busy;
  logic               done;
  logic               overflow;
  logic [COUNT_W-1:0] count;

  modport master (
    output start, abort, ro_in,
    input  ro_activate, busy, done, overflow, count
  );

  modport slave (
    input  start, abort, ro_in,
    output ro_activate, busy, done, overflow, count
  );
endinterface

// File: rtl/ro_edge_sync.sv
// Three-flop synchronizer for the asynchronous oscillator output,
// producing a one-cycle pulse for each synchronized rising edge.
module ro_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  // NOTE: rst_n is active-high despite its name, and is sampled synchronously.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enable, settle, count edges over a fixed
// gate window, then disable the oscillator and publish a saturating count.
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int COUNT_W    = DEF_COUNT_W,
  parameter int GATE_CYC   = DEF_GATE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input logic            clk,
  input logic            rst_n,
  ro_freq_meter_if.slave bus
);

  localparam int                 TMR_W     = timer_width(GATE_CYC, SETTLE_CYC);
  localparam logic [TMR_W-1:0]   SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0]   GATE_LD   = TMR_W'(GATE_CYC - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

  meter_state_e       state_q;
  logic [TMR_W-1:0]   timer_q;
  logic [COUNT_W-1:0] edges_q, edges_d;
  logic               sat_q, sat_d;
  logic [COUNT_W-1:0] count_q;
  logic               ovf_q;
  logic               act_q;
  logic               busy_q;
  logic               done_q;
  logic               rise;

  ro_edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(bus.ro_in),
    .rise_o (rise)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    edges_d = edges_q;
    sat_d   = sat_q;
    if (rise) begin
      if (edges_q == CNT_MAX) sat_d   = 1'b1;
      else                    edges_d = edges_q + COUNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      edges_q <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      act_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= SETTLE;
            timer_q <= SETTLE_LD;
            act_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SETTLE: begin
          if (bus.abort) begin
            state_q <= IDLE;
            act_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (timer_q == '0) begin
            state_q <= GATE;
            timer_q <= GATE_LD;
            edges_q <= '0;
            sat_q   <= 1'b0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        GATE: begin
          if (bus.abort) begin
            state_q <= IDLE;
            act_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            edges_q <= edges_d;
            sat_q   <= sat_d;
            if (timer_q == '0) begin
              // The final gate cycle's edge is folded into the published result.
              state_q <= DONE;
              count_q <= edges_d;
              ovf_q   <= sat_d;
              act_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              timer_q <= timer_q - TMR_W'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ro_activate = act_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.overflow    = ovf_q;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: a 16-bit and a 4-bit instance share stimulus and
// are compared every cycle against a timeline model of the measurement.
module tb_ro_freq_meter;

  localparam int GATE   = 64;
  localparam int SETTLE = 16;
  localparam int LAT    = SETTLE + GATE + 1;
  localparam int MAX_W  = 65535;
  localparam int MAX_N  = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ro_in = 1'b0;

  always #5 clk = ~clk;

  ro_freq_meter_if #(.COUNT_W(16)) bus_w ();
  ro_freq_meter_if #(.COUNT_W(4))  bus_n ();

  assign bus_w.start = start;
  assign bus_w.abort = abort;
  assign bus_w.ro_in = ro_in;
  assign bus_n.start = start;
  assign bus_n.abort = abort;
  assign bus_n.ro_in = ro_in;

  ro_freq_meter #(.COUNT_W(16), .GATE_CYC(GATE), .SETTLE_CYC(SETTLE)) dut_w (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_w)
  );

  ro_freq_meter #(.COUNT_W(4), .GATE_CYC(GATE), .SETTLE_CYC(SETTLE)) dut_n (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Oscillator stand-in: square wave of ro_period clk cycles, or a fixed level.
  int ro_period = 0;
  bit ro_level  = 1'b0;
  int gen_cnt   = 0;
  always @(negedge clk) begin
    gen_cnt++;
    if (ro_period == 0) ro_in = ro_level;
    else                ro_in = ((gen_cnt / (ro_period / 2)) % 2) == 1;
  end

  // Timeline model: edge numbers of the start, ro_in as sampled at each edge.
  bit hist [0:16383];
  int edge_no  = 0;
  bit m_valid  = 1'b0;
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_k      = 0;
  int m_cnt_w  = 0;
  int m_cnt_n  = 0;
  bit m_ovf_w  = 1'b0;
  bit m_ovf_n  = 1'b0;
  int rises;

  always @(posedge clk) begin
    hist[edge_no] = ro_in;
    if (rst_n) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_done   = 1'b0;
      m_cnt_w  = 0;
      m_cnt_n  = 0;
      m_ovf_w  = 1'b0;
      m_ovf_n  = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      if (abort) begin
        m_active = 1'b0;
      end else if (edge_no - m_k == SETTLE + GATE) begin
        // A rise seen after edge j is a sample pair (j-2 low, j-1 high).
        rises = 0;
        for (int j = m_k + SETTLE; j < m_k + SETTLE + GATE; j++)
          if (hist[j-1] && !hist[j-2]) rises++;
        m_cnt_w  = (rises > MAX_W) ? MAX_W : rises;
        m_ovf_w  = rises > MAX_W;
        m_cnt_n  = (rises > MAX_N) ? MAX_N : rises;
        m_ovf_n  = rises > MAX_N;
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (start) begin
      m_active = 1'b1;
      m_k      = edge_no;
    end
    edge_no++;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("act_w",   bus_w.ro_activate, m_active);
      check("busy_w",  bus_w.busy,        m_active);
      check("done_w",  bus_w.done,        m_done);
      check("count_w", bus_w.count,       m_cnt_w);
      check("ovf_w",   bus_w.overflow,    m_ovf_w);
      check("act_n",   bus_n.ro_activate, m_active);
      check("busy_n",  bus_n.busy,        m_active);
      check("done_n",  bus_n.done,        m_done);
      check("count_n", bus_n.count,       m_cnt_n);
      check("ovf_n",   bus_n.overflow,    m_ovf_n);
    end
  end

  int done_pulses = 0;
  always @(negedge clk) if (bus_w.done === 1'b1) done_pulses++;

  // Called at a negedge; returns cycles from start sample to done, and
  // how many of those cycles had the oscillator enabled.
  task automatic measure(input string tag, input bit with_abort, output int lat, output int act);
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    lat   = -1;
    act   = 0;
    for (int n = 1; n <= LAT + 20; n++) begin
      if (bus_w.done === 1'b1) begin
        lat = n;
        break;
      end
      if (bus_w.ro_activate === 1'b1) act++;
      @(negedge clk);
    end
    check({tag, " latency"}, lat, LAT);
    @(negedge clk);
    @(negedge clk);
  endtask

  int lat, act, d0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset count_w", bus_w.count, 0);
    check("reset act_w",   bus_w.ro_activate, 0);
    check("reset done_w",  bus_w.done, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    ro_period = 4;
    measure("nominal", 1'b0, lat, act);
    check("nominal act cycles", act, 80);
    check("nominal count_w", bus_w.count, 16);
    check("nominal ovf_w",   bus_w.overflow, 0);
    check("nominal count_n", bus_n.count, 15);
    check("nominal ovf_n",   bus_n.overflow, 1);

    ro_period = 0;
    ro_level  = 1'b0;
    measure("stuck0", 1'b0, lat, act);
    check("stuck0 count_w", bus_w.count, 0);
    check("stuck0 ovf_n",   bus_n.overflow, 0);
    ro_level = 1'b1;
    measure("stuck1", 1'b0, lat, act);
    check("stuck1 count_w", bus_w.count, 0);
    check("stuck1 count_n", bus_n.count, 0);

    ro_period = 2;
    measure("sat", 1'b0, lat, act);
    check("sat count_w", bus_w.count, 32);
    check("sat count_n", bus_n.count, 15);
    check("sat ovf_n",   bus_n.overflow, 1);
    ro_period = 16;
    measure("slow", 1'b0, lat, act);
    check("slow count_n", bus_n.count, 4);
    check("slow ovf_n",   bus_n.overflow, 0);

    ro_period = 4;
    measure("pre-abort", 1'b0, lat, act);
    check("pre-abort count_w", bus_w.count, 16);
    d0 = done_pulses;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort act_w",   bus_w.ro_activate, 0);
    check("abort busy_w",  bus_w.busy, 0);
    check("abort count_w", bus_w.count, 16);
    check("abort no done", done_pulses - d0, 0);
    measure("post-abort", 1'b0, lat, act);
    check("post-abort count_w", bus_w.count, 16);

    d0 = done_pulses;
    start = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= LAT; n++) begin
      start = (n % 2) == 1;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("busy single done", done_pulses - d0, 1);
    check("busy idle after",  bus_w.busy, 0);
    check("busy count_w",     bus_w.count, 16);

    measure("start+abort", 1'b1, lat, act);
    check("start+abort act cycles", act, 80);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    check("midrst act_w",   bus_w.ro_activate, 0);
    check("midrst busy_w",  bus_w.busy, 0);
    check("midrst done_w",  bus_w.done, 0);
    check("midrst count_w", bus_w.count, 0);
    check("midrst ovf_n",   bus_n.overflow, 0);
    @(negedge clk);
    measure("after reset", 1'b0, lat, act);
    check("after reset count_w", bus_w.count, 16);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
